// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: receive-side gray pointer CDC with pipelined gray->binary conversion
//   clk        local-domain clock
//   rst        asynchronous reset, active-high
//   gray_i     gray-coded value from the foreign domain
//   err_clr_i  synchronous clear of err_o
//   bin_o      binary value of the synchronized gray input
//   valid_o    bin_o / delta_o meaningful
//   delta_o    bin_o(now) - bin_o(previous), modulo 2^CNT_W
//   err_o      sticky flag: synchronized gray changed in more than one bit
module gray_ptr_sync #(
  parameter int CNT_W  = 8,
  parameter int SYNC_N = 2,
  parameter int PIPE_N = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] gray_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] bin_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] delta_o,
  output logic             err_o
);
  localparam int L  = SYNC_N + PIPE_N + 1;
  localparam int CW = $clog2(L + 1);
  logic [CNT_W-1:0] sync_q [SYNC_N];
  logic [CNT_W-1:0] sync_out, prev_q, bin_q, bin_d, delta_q, delta_d, diff;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d, viol;
  assign sync_out = sync_q[SYNC_N-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // Each stage converts one MSB-first segment [HI:LO]; bits above are already
  // binary, so bin[i] = bin[i+1] ^ gray[i] carries the running parity down.
  for (genvar k = 0; k <= PIPE_N; k++) begin : g_stg
    localparam int HI = CNT_W - (k * CNT_W) / (PIPE_N + 1) - 1;
    localparam int LO = CNT_W - ((k + 1) * CNT_W) / (PIPE_N + 1);
    logic [CNT_W-1:0] in_w, out_w;
    if (k == 0) begin : g_in
      assign in_w = sync_out;
    end else begin : g_in
      logic [CNT_W-1:0] q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= g_stg[k-1].out_w;
      end
      assign in_w = q;
    end
    always_comb begin
      out_w = in_w;
      for (int i = CNT_W - 2; i >= 0; i--)
        if (i >= LO && i <= HI) out_w[i] = out_w[i+1] ^ in_w[i];
    end
  end
  assign bin_d   = g_stg[PIPE_N].out_w;
  assign cnt_d   = (cnt_q == CW'(L)) ? cnt_q : cnt_q + CW'(1);
  // delta stays 0 until valid is already up, so the first valid delta is 0
  assign delta_d = (cnt_q == CW'(L)) ? bin_d - bin_q : '0;
  assign diff    = sync_out ^ prev_q;
  // prev_q only holds a synchronized sample once the chain has filled
  assign viol    = (cnt_q > CW'(SYNC_N)) && (|(diff & (diff - CNT_W'(1))));
  assign err_d   = viol ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= sync_out;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      err_q   <= err_d;
    end
  end
  assign bin_o   = bin_q;
  assign delta_o = delta_q;
  assign valid_o = (cnt_q == CW'(L));
  assign err_o   = err_q;
endmodule
